id_ex_skid_stage: RTL and testbench

- Parametrised successor to the fixed ID/EX pipeline register.
- Elastic ID->EX stage with a valid/ready handshake on both sides and a 2-entry skid buffer (main + skid register), so upstream ready is a registered signal.
- Adds flush (bubble insertion), bubble-gated control outputs and a saturating downstream-stall counter.
- Sits between the decode/hazard unit and the execute stage.

---
 rtl/id_ex_skid_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_skid_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage.sv
// ID->EX elastic stage: main + skid register so upstream ready is registered.
// Latency: an accepted entry is presented one cycle later; a stalled entry holds its payload.
// Backpressure: in_ready drops only when both registers are occupied; flush empties the stage.
module id_ex_skid_stage #(
    parameter int CTRL_W = 25,
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_pa,
    input  logic [DATA_W-1:0] in_pb,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs_addr,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IMM_W-1:0]  out_imm,
    output logic [DATA_W-1:0] out_pa,
    output logic [DATA_W-1:0] out_pb,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_addr,
    output logic [DATA_W-1:0] out_instr,
    output logic [DEST_W-1:0] out_dest,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [IMM_W-1:0]  imm;
        logic [DATA_W-1:0] pa;
        logic [DATA_W-1:0] pb;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_addr;
        logic [DATA_W-1:0] instr;
        logic [DEST_W-1:0] dest;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_ent;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_q;
    logic             accept;
    logic             fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_ent = {in_ctrl, in_imm, in_pa, in_pb, in_pc, in_rs_addr, in_instr, in_dest};

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign fire      = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        // Flush drops both held entries and anything handshaking this cycle.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (load_main_in) begin
                main_q <= in_ent;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_ent;
            end
            if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    // A bubble must look like a NOP downstream, so control is gated by valid.
    assign out_ctrl    = out_valid ? main_q.ctrl : '0;
    assign out_imm     = main_q.imm;
    assign out_pa      = main_q.pa;
    assign out_pb      = main_q.pb;
    assign out_pc      = main_q.pc;
    assign out_rs_addr = main_q.rs_addr;
    assign out_instr   = main_q.instr;
    assign out_dest    = main_q.dest;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed vector table, corner sequences, randomized queue-model run.
module tb_id_ex_skid_stage;

    localparam int CTRL_W = 25;
    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [IMM_W-1:0]  in_imm = '0;
    logic [DATA_W-1:0] in_pa = '0;
    logic [DATA_W-1:0] in_pb = '0;
    logic [DATA_W-1:0] in_pc = '0;
    logic [DATA_W-1:0] in_rs_addr = '0;
    logic [DATA_W-1:0] in_instr = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [IMM_W-1:0]  out_imm;
    logic [DATA_W-1:0] out_pa;
    logic [DATA_W-1:0] out_pb;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_rs_addr;
    logic [DATA_W-1:0] out_instr;
    logic [DEST_W-1:0] out_dest;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    id_ex_skid_stage #(
        .CTRL_W(CTRL_W), .IMM_W(IMM_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_imm(in_imm), .in_pa(in_pa), .in_pb(in_pb), .in_pc(in_pc),
        .in_rs_addr(in_rs_addr), .in_instr(in_instr), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pa(out_pa), .out_pb(out_pb), .out_pc(out_pc),
        .out_rs_addr(out_rs_addr), .out_instr(out_instr), .out_dest(out_dest),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [IMM_W-1:0]  imm;
        logic [DATA_W-1:0] pa;
        logic [DATA_W-1:0] pb;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_addr;
        logic [DATA_W-1:0] instr;
        logic [DEST_W-1:0] dest;
    } pay_t;

    typedef struct {
        logic        iv, ord, fl;
        logic [31:0] instr;
        logic [24:0] ctrl;
        logic        ev, er;
        logic [31:0] ei;
        logic [24:0] ec;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pay_t mk(input logic [31:0] i, input logic [24:0] c);
        pay_t p;
        p.ctrl    = c;
        p.imm     = i[15:0] ^ 16'h5A5A;
        p.pa      = i ^ 32'h1111_1111;
        p.pb      = ~i;
        p.pc      = i << 2;
        p.rs_addr = i + 32'd7;
        p.instr   = i;
        p.dest    = i[4:0] ^ 5'h15;
        return p;
    endfunction

    function automatic pay_t rnd_pay();
        pay_t p;
        p.ctrl    = CTRL_W'($urandom);
        p.imm     = IMM_W'($urandom);
        p.pa      = $urandom;
        p.pb      = $urandom;
        p.pc      = $urandom;
        p.rs_addr = $urandom;
        p.instr   = $urandom;
        p.dest    = DEST_W'($urandom);
        return p;
    endfunction

    task automatic set_in(input logic iv, input logic ord, input logic fl, input pay_t p);
        in_valid   = iv;
        out_ready  = ord;
        flush      = fl;
        in_ctrl    = p.ctrl;
        in_imm     = p.imm;
        in_pa      = p.pa;
        in_pb      = p.pb;
        in_pc      = p.pc;
        in_rs_addr = p.rs_addr;
        in_instr   = p.instr;
        in_dest    = p.dest;
    endtask

    task automatic add(input logic iv, input logic ord, input logic fl, input logic [31:0] instr,
                       input logic [24:0] ctrl, input logic ev, input logic er, input logic [31:0] ei,
                       input logic [24:0] ec, input logic [3:0] ecnt);
        vec_t v;
        v.iv = iv; v.ord = ord; v.fl = fl; v.instr = instr; v.ctrl = ctrl;
        v.ev = ev; v.er = er; v.ei = ei; v.ec = ec; v.ecnt = ecnt;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of held entries plus the last entry seen at the head.
    pay_t             mq[$];
    pay_t             m_last;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_step(input logic iv, input logic ord, input logic fl, input pay_t p);
        int pre;
        pre = mq.size();
        if (pre > 0 && !ord && !fl && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pre > 0 && ord) void'(mq.pop_front());
            if (iv && pre < 2) mq.push_back(p);
        end
        if (mq.size() > 0) m_last = mq[0];
    endtask

    initial begin
        pay_t p;
        pay_t got;
        pay_t expp;
        logic [CNT_W-1:0] ecnt;

        // Directed table: 8-deep stream, backpressure into FULL, bubble gating, flushes.
        for (int i = 0; i < 8; i++) add(1, 1, 0, i + 1, i + 1, 1, 1, i + 1, i + 1, 0);
        add(0, 1, 0, 0,            0,          0, 1, 32'h8,        0,          0);
        add(1, 0, 0, 32'hAAAA0000, 25'hAA,     1, 1, 32'hAAAA0000, 25'hAA,     0);
        add(1, 0, 0, 32'hBBBB0000, 25'hBB,     1, 0, 32'hAAAA0000, 25'hAA,     1);
        add(1, 0, 0, 32'hCCCC0000, 25'hCC,     1, 0, 32'hAAAA0000, 25'hAA,     2);
        add(0, 0, 0, 0,            0,          1, 0, 32'hAAAA0000, 25'hAA,     3);
        add(0, 1, 0, 0,            0,          1, 1, 32'hBBBB0000, 25'hBB,     3);
        add(0, 1, 0, 0,            0,          0, 1, 32'hBBBB0000, 0,          3);
        add(1, 0, 0, 32'h11,       25'h1FFFFFF, 1, 1, 32'h11,      25'h1FFFFFF, 3);
        add(0, 1, 0, 0,            0,          0, 1, 32'h11,       0,          3);
        add(1, 0, 0, 32'hA2,       25'h1,      1, 1, 32'hA2,       25'h1,      3);
        add(1, 0, 0, 32'hB2,       25'h2,      1, 0, 32'hA2,       25'h1,      4);
        add(1, 1, 1, 32'hC2,       25'h3,      0, 1, 32'hA2,       0,          4);
        add(0, 1, 0, 0,            0,          0, 1, 32'hA2,       0,          4);
        add(1, 0, 0, 32'hD0,       25'h4,      1, 1, 32'hD0,       25'h4,      4);
        add(0, 0, 1, 0,            0,          0, 1, 32'hD0,       0,          4);
        add(1, 1, 0, 32'hE0,       25'h5,      1, 1, 32'hE0,       25'h5,      4);
        add(1, 1, 1, 32'hF0,       25'h6,      0, 1, 32'hE0,       0,          4);
        add(0, 1, 0, 0,            0,          0, 1, 32'hE0,       0,          4);

        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        got = {out_ctrl, out_imm, out_pa, out_pb, out_pc, out_rs_addr, out_instr, out_dest};
        chk("rst_payload", got, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[k]) begin
            set_in(vt[k].iv, vt[k].ord, vt[k].fl, mk(vt[k].instr, vt[k].ctrl));
            tick();
            chk($sformatf("vec%0d_out_valid", k), out_valid, vt[k].ev);
            chk($sformatf("vec%0d_in_ready", k), in_ready, vt[k].er);
            chk($sformatf("vec%0d_out_instr", k), out_instr, vt[k].ei);
            chk($sformatf("vec%0d_out_ctrl", k), out_ctrl, vt[k].ec);
            chk($sformatf("vec%0d_stall_cnt", k), stall_cnt, vt[k].ecnt);
        end

        // Saturation: one entry held under a long stall; counter climbs from 4 and sticks at 15.
        set_in(1, 0, 0, mk(32'h600D, 25'h7));
        tick();
        set_in(0, 0, 0, mk(0, 0));
        for (int k = 1; k <= 20; k++) begin
            tick();
            ecnt = (4 + k > 15) ? 4'hF : 4'(4 + k);
            chk($sformatf("sat%0d_stall_cnt", k), stall_cnt, ecnt);
        end
        chk("sat_out_instr", out_instr, 32'h600D);
        chk("sat_out_valid", out_valid, 1);
        set_in(0, 1, 0, mk(0, 0));
        tick();
        chk("sat_drain_valid", out_valid, 0);

        // Asynchronous reset while FULL, then first accept right after release.
        set_in(1, 0, 0, mk(32'h7001, 25'h71));
        tick();
        set_in(1, 0, 0, mk(32'h7002, 25'h72));
        tick();
        chk("pre_areset_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_out_ctrl", out_ctrl, 0);
        chk("areset_stall_cnt", stall_cnt, 0);
        chk("areset_in_ready", in_ready, 1);
        chk("areset_out_instr", out_instr, 0);
        set_in(1, 1, 0, mk(32'h7003, 25'h73));
        #1 reset = 1'b0;
        tick();
        chk("post_areset_valid", out_valid, 1);
        chk("post_areset_instr", out_instr, 32'h7003);
        chk("post_areset_ctrl", out_ctrl, 25'h73);

        // Randomized run against the queue model, with an occasional asynchronous reset.
        set_in(0, 0, 0, mk(0, 0));
        reset = 1'b1;
        #1 reset = 1'b0;
        mq.delete();
        m_last = '0;
        m_cnt  = '0;
        for (int c = 0; c < 1500; c++) begin
            logic iv, ord, fl;
            if (c % 300 == 299) begin
                reset = 1'b1;
                #1 reset = 1'b0;
                mq.delete();
                m_last = '0;
                m_cnt  = '0;
            end
            iv  = ($urandom_range(0, 3) != 0);
            ord = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            p   = rnd_pay();
            set_in(iv, ord, fl, p);
            model_step(iv, ord, fl, p);
            tick();
            expp = m_last;
            if (mq.size() == 0) expp.ctrl = '0;
            got = {out_ctrl, out_imm, out_pa, out_pb, out_pc, out_rs_addr, out_instr, out_dest};
            chk($sformatf("rnd%0d_out_valid", c), out_valid, (mq.size() > 0));
            chk($sformatf("rnd%0d_in_ready", c), in_ready, (mq.size() < 2));
            chk($sformatf("rnd%0d_payload", c), got, expp);
            chk($sformatf("rnd%0d_stall_cnt", c), stall_cnt, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
